// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using the shift-and-add-3 method.
// It advances one bit per ce strobe and produces four packed BCD digits.
// Inputs above 9999 saturate the display value to 9999 and raise ovf.
//
// Handshake: a start is accepted only on a clock edge where ce=1, st=1 and the
// block is idle (busy=0). di is captured at that edge and ignored afterwards.
// The result appears on dat together with a single-cycle done pulse.
// st is ignored while busy=1 and is never queued.
module bin2bcd_seq #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         R,
    input  logic         ce,
    input  logic         st,
    input  logic [W-1:0] di,
    output logic [15:0]  dat,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic [1:0]   state_dbg
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    sr;
    logic [15:0]     bcd;
    logic [15:0]     bcd_adj;
    logic [15:0]     bcd_shift;
    logic [CW-1:0]   cnt;
    logic            cmp;
    logic            start;
    logic            step;
    logic            last;

    assign state_dbg = state;

    // State register; the next-state logic maps unused encodings back to IDLE.
    always_ff @(posedge clk) begin
        if (R) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (ce && st) begin
                    start     = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (ce) begin
                    step = 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        last      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Add 3 to every BCD nibble of 5 or more, then shift in the next binary MSB.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[14:0], sr[W-1]};
    end

    // Conversion datapath and result/status registers.
    always_ff @(posedge clk) begin
        if (R) begin
            sr   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            cmp  <= 1'b0;
            dat  <= 16'h0000;
            ovf  <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state_nxt == SHIFT);
            if (start) begin
                sr  <= di;
                bcd <= '0;
                cnt <= '0;
                cmp <= (32'(di) > 32'd9999);
            end else if (step) begin
                sr  <= {sr[W-2:0], 1'b0};
                bcd <= bcd_shift;
                cnt <= cnt + 1'b1;
                if (last) begin
                    dat  <= cmp ? 16'h9999 : bcd_shift;
                    ovf  <= cmp;
                    done <= 1'b1;
                    cnt  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq (W=14).
module tb_bin2bcd_seq;

    logic        clk;
    logic        R;
    logic        ce;
    logic        st;
    logic [13:0] di;
    logic [15:0] dat;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    bin2bcd_seq #(.W(14)) dut (
        .clk       (clk),
        .R         (R),
        .ce        (ce),
        .st        (st),
        .di        (di),
        .dat       (dat),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .state_dbg (state_dbg)
    );

    // Clock and global timeout.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Advance one edge; inputs are changed and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a conversion with ce strobed every 'period' clocks.
    // Returns the number of ce pulses to done, busy samples, dat/ovf at done,
    // and the done level one cycle after the pulse.
    task automatic do_conv(input logic [13:0] v, input int period, input bit st_busy,
                           output int ce_pulses, output int busy_cnt,
                           output logic [15:0] d, output logic o, output logic done_after);
        int i;
        di = v;
        st = 1'b1;
        ce = 1'b1;
        tick();
        busy_cnt  = busy ? 1 : 0;
        ce_pulses = 0;
        st        = 1'b0;
        di        = 14'($urandom_range(0, 16383));
        d         = 16'hxxxx;
        o         = 1'bx;
        i         = 1;
        while (i < 400) begin
            ce = ((i % period) == 0);
            st = st_busy && (ce_pulses < 10);
            if (ce) ce_pulses++;
            tick();
            if (done) break;
            if (busy) busy_cnt++;
            i++;
        end
        d  = dat;
        o  = ovf;
        st = 1'b0;
        ce = 1'b1;
        tick();
        done_after = done;
    endtask

    task automatic test_reset();
        R  = 1'b1;
        ce = 1'b1;
        st = 1'b1;
        di = 14'd1234;
        tick();
        tick();
        checks++; if (dat !== 16'h0000) begin errors++; $display("FAIL reset_dat: got %h want 0000", dat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        st = 1'b0;
        R  = 1'b0;
        tick();
    endtask

    task automatic test_zero();
        int p, b;
        logic [15:0] d;
        logic o, da;
        do_conv(14'd0, 1, 1'b0, p, b, d, o, da);
        checks++; if (p !== 14) begin errors++; $display("FAIL zero_latency: got %0d want 14", p); end
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL zero_dat: got %h want 0000", d); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL zero_ovf: got %b want 0", o); end
    endtask

    task automatic test_values();
        int p, b;
        logic [15:0] d;
        logic o, da;
        do_conv(14'd1234, 1, 1'b0, p, b, d, o, da);
        checks++; if (p !== 14) begin errors++; $display("FAIL v1234_latency: got %0d want 14", p); end
        checks++; if (b !== 14) begin errors++; $display("FAIL v1234_busy_cycles: got %0d want 14", b); end
        checks++; if (d !== 16'h1234) begin errors++; $display("FAIL v1234_dat: got %h want 1234", d); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL v1234_done_width: got %b want 0", da); end
        do_conv(14'd9999, 1, 1'b0, p, b, d, o, da);
        checks++; if (d !== 16'h9999) begin errors++; $display("FAIL v9999_dat: got %h want 9999", d); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL v9999_ovf: got %b want 0", o); end
        do_conv(14'd8050, 1, 1'b0, p, b, d, o, da);
        checks++; if (d !== 16'h8050) begin errors++; $display("FAIL v8050_dat: got %h want 8050", d); end
    endtask

    task automatic test_overflow();
        int p, b;
        logic [15:0] d;
        logic o, da;
        do_conv(14'd10000, 1, 1'b0, p, b, d, o, da);
        checks++; if (d !== 16'h9999) begin errors++; $display("FAIL ovf10000_dat: got %h want 9999", d); end
        checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf10000_ovf: got %b want 1", o); end
        ce = 1'b1;
        repeat (5) tick();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b want 1", ovf); end
        checks++; if (dat !== 16'h9999) begin errors++; $display("FAIL dat_hold: got %h want 9999", dat); end
        do_conv(14'd42, 1, 1'b0, p, b, d, o, da);
        checks++; if (d !== 16'h0042) begin errors++; $display("FAIL v42_dat: got %h want 0042", d); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL v42_ovf: got %b want 0", o); end
    endtask

    task automatic test_start_ce0();
        ce = 1'b0;
        st = 1'b1;
        di = 14'd555;
        tick();
        st = 1'b0;
        ce = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_ce0_busy: got %b want 0", busy); end
        checks++; if (dat !== 16'h0042) begin errors++; $display("FAIL start_ce0_dat: got %h want 0042", dat); end
    endtask

    task automatic test_slow_ce();
        int p, b, extra;
        logic [15:0] d;
        logic o, da;
        do_conv(14'd5678, 3, 1'b1, p, b, d, o, da);
        checks++; if (p !== 14) begin errors++; $display("FAIL slow_ce_pulses: got %0d want 14", p); end
        checks++; if (d !== 16'h5678) begin errors++; $display("FAIL slow_dat: got %h want 5678", d); end
        extra = da ? 1 : 0;
        ce = 1'b1;
        st = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL slow_extra_done: got %0d want 0", extra); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL slow_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_abort();
        int p, b, dn;
        logic [15:0] d;
        logic o, da;
        di = 14'd777;
        st = 1'b1;
        ce = 1'b1;
        tick();
        st = 1'b0;
        repeat (5) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        R = 1'b1;
        tick();
        R = 1'b0;
        checks++; if (dat !== 16'h0000) begin errors++; $display("FAIL abort_dat: got %h want 0000", dat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        dn = done ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dn++;
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", dn); end
        do_conv(14'd777, 1, 1'b0, p, b, d, o, da);
        checks++; if (d !== 16'h0777) begin errors++; $display("FAIL restart_dat: got %h want 0777", d); end
    endtask

    task automatic test_back_to_back();
        int t, t1, t2, n;
        logic [15:0] d1, d2;
        t  = 0;
        n  = 0;
        t1 = -1;
        t2 = -1;
        d1 = 16'hxxxx;
        d2 = 16'hxxxx;
        di = 14'd1;
        st = 1'b1;
        ce = 1'b1;
        tick();
        while (t < 100 && n < 2) begin
            tick();
            t++;
            if (done) begin
                n++;
                if (n == 1) begin
                    t1 = t;
                    d1 = dat;
                    di = 14'd2;
                end else begin
                    t2 = t;
                    d2 = dat;
                end
            end
        end
        st = 1'b0;
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", n); end
        checks++; if (t1 !== 14) begin errors++; $display("FAIL b2b_first_latency: got %0d want 14", t1); end
        checks++; if ((t2 - t1) !== 15) begin errors++; $display("FAIL b2b_spacing: got %0d want 15", t2 - t1); end
        checks++; if (d1 !== 16'h0001) begin errors++; $display("FAIL b2b_dat1: got %h want 0001", d1); end
        checks++; if (d2 !== 16'h0002) begin errors++; $display("FAIL b2b_dat2: got %h want 0002", d2); end
    endtask

    initial begin
        R  = 1'b1;
        ce = 1'b0;
        st = 1'b0;
        di = '0;
        test_reset();
        test_zero();
        test_values();
        test_overflow();
        test_start_ce0();
        test_slow_ce();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter: W, default 14, binary input width; legal range 4..14.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 R  input  1  reset, synchronous, active-high; sampled on rising edge of clk.
REQ-004 ce  input  1  clock enable (1 ms / CEO-style strobe); conversion steps only in ce=1 cycles.
REQ-005 st  input  1  start strobe; sampled only when ce=1 and block idle.
REQ-006 di  input  W  unsigned binary value to convert; sampled at start acceptance only.
REQ-007 dat  output  16  packed BCD result, digit 3 in [15:12] to digit 0 in [3:0]; feeds 4-digit display dat bus directly.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-clk pulse marking dat update.
REQ-010 ovf  output  1  high when last accepted di exceeded 9999; held until next completion.

Function
REQ-011 States: IDLE, SHIFT; no other reachable states; illegal encodings return to IDLE next clk.
REQ-012 IDLE, ce=1, st=1: latch di into shift register, clear 16-bit BCD accumulator, step count=0, latch cmp=(di>9999), go SHIFT.
REQ-013 IDLE, st=1 with ce=0: start ignored, not queued.
REQ-014 SHIFT, ce=1: per digit, add 3 to any BCD nibble >=5, then shift {BCD,bin} left 1 bit, step count+1.
REQ-015 SHIFT, ce=0: all internal state frozen; busy stays 1.
REQ-016 On the step with count reaching W: write result to dat (or 16'h9999 if cmp=1), ovf<=cmp, done<=1, state IDLE.
REQ-017 done high for exactly one clk cycle after the completing edge, independent of ce; low otherwise.
REQ-018 busy=1 exactly while state=SHIFT; registered output.
REQ-019 Latency: with ce held 1, st accepted at edge k gives done=1 and new dat after edge k+W (W=14: 14 clks).
REQ-020 st while busy ignored; in-flight conversion unaffected; di changes after acceptance ignored.
REQ-021 dat and ovf change only at completion or reset; hold between conversions.
REQ-022 Accumulator 16 bits, no carry out of digit 3 for di<=9999; saturation per REQ-016 covers di>9999.
REQ-023 Completion cycle with st=1: new start not accepted that edge; accepted earliest next ce=1 edge in IDLE.

Reset
REQ-024 R=1 at rising edge: state IDLE, dat=16'h0000, busy=0, done=0, ovf=0, step count=0, shift register cleared.
REQ-025 R overrides ce and st; R mid-conversion aborts with no done pulse and dat=0.
REQ-026 First st accepted on first ce=1 edge with R=0.

Verification
REQ-027 R, then di=0, st pulse, ce=1 -> done after 14 clks, dat=16'h0000, ovf=0.
REQ-028 di=1234, ce=1 -> dat=16'h1234 with done at edge k+14; busy high 14 clks; di=9999 -> dat=16'h9999, ovf=0.
REQ-029 di=10000 -> dat=16'h9999, ovf=1; following di=42 -> dat=16'h0042, ovf=0.
REQ-030 di=5678 with ce=1 every 3rd clk -> done after 14 ce pulses, dat=16'h5678; st pulses while busy produce no extra done.
REQ-031 di=777 started, R asserted after 5 steps -> next clk dat=0, busy=0, no done; restart di=777 -> dat=16'h0777.
REQ-032 Back-to-back: st held 1, ce=1, di=1 then 2 -> two done pulses 15 clks apart, dat=16'h0001 then 16'h0002.
